// File: rtl/exception_pkg.sv
// Shared types and cause codes for the exception controller.
package exception_pkg;
  localparam int ESTATUS_W = 4;

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_e;

  localparam logic [ESTATUS_W-1:0] ECODE_NONE     = 4'h0;
  localparam logic [ESTATUS_W-1:0] ECODE_ILLEGAL  = 4'h1;
  localparam logic [ESTATUS_W-1:0] ECODE_IRQ_BASE = 4'h8;
endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority cause encoder: illegal instruction first, then lowest IRQ index.
module exc_priority_enc
  import exception_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic                 illegal_instr,
  input  logic [NUM_IRQ-1:0]   req,
  output logic                 valid,
  output logic [ESTATUS_W-1:0] code,
  output logic [NUM_IRQ-1:0]   grant
);

  always_comb begin
    valid = illegal_instr | (|req);
    code  = ECODE_NONE;
    grant = '0;
    // Scan high to low so the lowest requesting line ends up winning.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        code     = ECODE_IRQ_BASE + ESTATUS_W'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    if (illegal_instr) begin
      code  = ECODE_ILLEGAL;
      grant = '0;
    end
  end

endmodule

// File: rtl/exception_controller.sv
// Exception sequencer: IRQ edge capture, masking, arbitration, Exc/ExcAck handshake, ERET.
// Optional ExcAck timeout (with ack_timeout port) enabled by defining EXC_ACK_TIMEOUT_EN.
module exception_controller
  import exception_pkg::*;
#(
  parameter int NUM_IRQ = 4
`ifdef EXC_ACK_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 illegal_instr,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic                 eret_in,
  input  logic                 mask_we,
  input  logic [NUM_IRQ-1:0]   mask_wdata,
  input  logic                 ExcAck,
  output logic                 Exc,
  output logic [ESTATUS_W-1:0] EStatus,
  output logic                 ERet,
  output logic                 in_handler,
  output logic [NUM_IRQ-1:0]   pending,
  output logic                 double_fault
`ifdef EXC_ACK_TIMEOUT_EN
  , output logic               ack_timeout
`endif
);

  state_e               state_q, state_d;
  logic                 exc_q, exc_d, eret_q, eret_d, inh_q, inh_d, df_q, df_d;
  logic [ESTATUS_W-1:0] est_q, est_d;
  logic [NUM_IRQ-1:0]   pend_q, pend_d, mask_q, mask_d, prev_q, taken_q, taken_d;
  logic [NUM_IRQ-1:0]   irq_rise, clr, win_grant;
  logic [ESTATUS_W-1:0] win_code;
  logic                 win_valid;

`ifdef EXC_ACK_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  assign ack_timeout = to_q;
`endif

  exc_priority_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
    .illegal_instr(illegal_instr),
    .req          (pend_q & mask_q),
    .valid        (win_valid),
    .code         (win_code),
    .grant        (win_grant)
  );

  assign irq_rise = irq & ~prev_q;

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    est_d   = est_q;
    eret_d  = 1'b0;
    inh_d   = inh_q;
    df_d    = df_q;
    taken_d = taken_q;
    clr     = '0;
    mask_d  = mask_we ? mask_wdata : mask_q;
`ifdef EXC_ACK_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = REQ;
          exc_d   = 1'b1;
          est_d   = win_code;
          taken_d = win_grant;
`ifdef EXC_ACK_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (ExcAck) begin
          state_d = HANDLER;
          exc_d   = 1'b0;
          inh_d   = 1'b1;
          clr     = taken_q;
        end
`ifdef EXC_ACK_TIMEOUT_EN
        // Abandon the request; pending is left intact so it re-arbitrates.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          exc_d   = 1'b0;
          est_d   = ECODE_NONE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      HANDLER: begin
        if (illegal_instr) df_d = 1'b1;
        if (eret_in) begin
          state_d = IDLE;
          eret_d  = 1'b1;
          inh_d   = 1'b0;
          est_d   = ECODE_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge in the ack cycle beats the clear of the taken line.
    pend_d = (pend_q & ~clr) | irq_rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      exc_q   <= 1'b0;
      est_q   <= ECODE_NONE;
      eret_q  <= 1'b0;
      inh_q   <= 1'b0;
      df_q    <= 1'b0;
      pend_q  <= '0;
      mask_q  <= '1;
      prev_q  <= '0;
      taken_q <= '0;
`ifdef EXC_ACK_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      est_q   <= est_d;
      eret_q  <= eret_d;
      inh_q   <= inh_d;
      df_q    <= df_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      prev_q  <= irq;
      taken_q <= taken_d;
`ifdef EXC_ACK_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign Exc          = exc_q;
  assign EStatus      = est_q;
  assign ERet         = eret_q;
  assign in_handler   = inh_q;
  assign pending      = pend_q;
  assign double_fault = df_q;

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
Sequences the exception path of the single-cycle processor. It collects an illegal-instruction flag from the decoder and NUM_IRQ external interrupt lines, then prioritises them. It drives Exc/EStatus to the datapath, holds them until the datapath returns ExcAck, and tracks in-handler state until a decoded ERET, which it forwards as a one-cycle ERet pulse. It sits between the decoder/IRQ sources and the datapath's exception inputs.

Parameters:
NUM_IRQ, 4, number of external interrupt lines (1..7)
TIMEOUT, 16, cycles to wait for ExcAck before abandoning a request (optional feature only)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
illegal_instr  in  1  decoder flag: current instruction is not a valid opcode (level, per cycle)
irq  in  NUM_IRQ  external interrupt lines, synchronous to clk, edge-triggered
eret_in  in  1  decoder flag: current instruction is ERET
mask_we  in  1  write strobe for the IRQ mask register
mask_wdata  in  NUM_IRQ  new mask value; 1 = line enabled
ExcAck  in  1  datapath acknowledge: exception vector taken this cycle
Exc  out  1  exception request to datapath
EStatus  out  4  exception cause code to datapath
ERet  out  1  one-cycle return-from-exception to datapath
in_handler  out  1  1 while the handler runs
pending  out  NUM_IRQ  latched, not-yet-taken IRQ edges (unmasked and masked)
double_fault  out  1  sticky: illegal instruction seen while in_handler

Behaviour:
- Reset (async): state=IDLE; Exc=0, EStatus=0, ERet=0, in_handler=0, pending=0, double_fault=0, mask=all ones, irq edge history=0.
- Cause codes: 4'h0 none; 4'h1 illegal instruction; 4'h8+i IRQ line i.
- Priority: illegal_instr > irq[0] > irq[1] > ... ; only masked-in (mask[i]=1) pending bits compete.
- IRQ capture: rising edge of irq[i] (irq[i]=1, previous sample 0) sets pending[i] in any state. Masked lines still latch and raise once unmasked.
- Mask: mask_we writes mask next edge; takes effect for arbitration the following cycle.
- FSM IDLE: Exc=0. If illegal_instr or any enabled pending → REQ next cycle; winning code registered into EStatus. Otherwise stay IDLE. eret_in ignored.
- FSM REQ: Exc=1; EStatus held constant regardless of new events. On ExcAck → HANDLER, Exc=0 next cycle, clear pending bit of the taken IRQ (none for code 1). Latency: cause sampled in IDLE cycle t → Exc=1 at t+1.
- FSM HANDLER: in_handler=1, Exc=0, EStatus holds last code. New IRQ edges latch but do not request (no nesting). illegal_instr sets double_fault (sticky until reset). eret_in → ERet=1 for exactly one cycle, next state IDLE, EStatus=0.
- Simultaneous set/clear of same pending bit (edge in ack cycle): set wins, bit stays 1.
- ExcAck outside REQ: ignored.
- Back-to-back: a pending IRQ present when ERET retires is requested from IDLE on the following cycle.
- Reset mid-REQ or mid-HANDLER: immediate return to reset values; no ERet emitted.

Optional Feature:
EXC_ACK_TIMEOUT_EN: when defined, an 8-bit-or-wider counter runs in REQ. If ExcAck is not seen within TIMEOUT cycles, the FSM returns to IDLE with Exc=0 and sets sticky output ack_timeout (extra 1-bit port, reset 0). The pending bit is kept, so the request re-arbitrates. When not defined, there is no counter and no port, and REQ waits indefinitely.

Decomposition:
- Package exception_pkg: state enum (IDLE, REQ, HANDLER), cause constants ECODE_NONE=4'h0, ECODE_ILLEGAL=4'h1, ECODE_IRQ_BASE=4'h8, EStatus width constant 4.
- One sub-module: exc_priority_enc, combinational encoder producing the winning code and a one-hot grant from illegal_instr and pending&mask.

Test Plan:
- Reset mid-REQ (Exc=1) → all outputs 0 the same cycle; mask reads back all ones via arbitration (irq[3] edge then requests code 4'hB).
- irq[2] edge in IDLE → Exc=1, EStatus=4'hA next cycle; ExcAck → in_handler=1, pending[2]=0; eret_in → single ERet pulse, back to IDLE.
- illegal_instr with irq[0] and irq[1] pending → EStatus=4'h1 first; after ERET, 4'h8 next, then 4'h9.
- mask=4'b1110, irq[0] edge → pending[0]=1, no Exc; write mask=4'b1111 → Exc, EStatus=4'h8 two cycles later.
- In HANDLER: illegal_instr=1 → double_fault=1, stays 1 after ERET; irq[1] edge during handler stays pending and is requested after ERET.
- EXC_ACK_TIMEOUT_EN, TIMEOUT=16, no ExcAck → Exc drops after 16 REQ cycles, ack_timeout=1, request reissued.
